// File: rtl/data_memory_lsu_if.sv
// Bus interface between the MEM stage and data_memory_lsu.
//   master (core side): drives req, we, funct3, addr, wdata, fault_clr
//                       and receives rdata, rvalid, fault, fault_addr, fault_sticky.
//   slave  (memory)   : the mirror image.
// N is the data width in bits (32 or 64). A is the address width in bits.
interface data_memory_lsu_if #(
  parameter int unsigned N = 32,
  parameter int unsigned A = 32
);
  logic         req;
  logic         we;
  logic [2:0]   funct3;
  logic [A-1:0] addr;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic         rvalid;
  logic         fault;
  logic [A-1:0] fault_addr;
  logic         fault_sticky;
  logic         fault_clr;

  modport master (
    output req, we, funct3, addr, wdata, fault_clr,
    input  rdata, rvalid, fault, fault_addr, fault_sticky
  );

  modport slave (
    input  req, we, funct3, addr, wdata, fault_clr,
    output rdata, rvalid, fault, fault_addr, fault_sticky
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory for the MEM stage with sub-word loads/stores.
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous active-high reset (does not clear storage)
//   bus  : data_memory_lsu_if slave port
//          req/we/funct3/addr/wdata/fault_clr in; rdata/rvalid/fault/fault_addr/fault_sticky out
// Stores commit at the edge they are sampled. Loads return one cycle later, sign- or
// zero-extended. Misaligned, out-of-range and illegal accesses trap without side effects
// other than the fault outputs; the first trapping address is held until fault_clr.
module data_memory_lsu #(
  parameter int unsigned N    = 32,
  parameter int unsigned A    = 32,
  parameter int unsigned SIZE = 16384
) (
  input logic              clk,
  input logic              rst,
  data_memory_lsu_if.slave bus
);

  localparam int unsigned NB    = N / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned WORDS = SIZE / NB;
  localparam int unsigned WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [A:0]  SizeLim = (A + 1)'(SIZE);

  // Response state; the bit pattern is {fault, rvalid} so the outputs come straight off it.
  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StRespLoad  = 2'b01,
    StRespFault = 2'b10
  } state_e;

  logic [N-1:0] mem [WORDS];

  logic [3:0]     size_b;
  logic [LB-1:0]  lane;
  logic [WIW-1:0] widx;
  logic           illegal;
  logic           misaligned;
  logic           out_of_range;
  logic           trap;
  logic           do_store;
  logic           do_load;
  logic [NB-1:0]  be;
  logic [N-1:0]   wdata_sh;

  // Access decode and trap detection.
  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   size_b = 4'd1;
      2'b01:   size_b = 4'd2;
      2'b10:   size_b = 4'd4;
      default: size_b = 4'd8;
    endcase
    lane         = bus.addr[LB-1:0];
    widx         = bus.addr[LB +: WIW];
    misaligned   = (bus.addr[2:0] & 3'(size_b - 4'd1)) != 3'b000;
    out_of_range = {1'b0, bus.addr} >= SizeLim;
    illegal      = (bus.funct3 == 3'b111)
                || ((N == 32) && ((bus.funct3 == 3'b011) || (bus.funct3 == 3'b110)))
                || (bus.we && bus.funct3[2]);
    trap         = bus.req && (illegal || misaligned || out_of_range);
    do_store     = bus.req && bus.we && !trap;
    do_load      = bus.req && !bus.we && !trap;
    wdata_sh     = bus.wdata << {lane, 3'b000};
    be           = '0;
    for (int b = 0; b < int'(NB); b++) begin
      be[b] = (b >= int'(lane)) && (b < int'(lane) + int'(size_b));
    end
  end

  // Storage is not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) begin
          mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  logic [N-1:0] rd_word;
  logic [N-1:0] rd_sh;
  logic [N-1:0] ld_data;
  logic         sign_bit;
  int           nbits;

  // Lane extraction and extension of the loaded bytes.
  always_comb begin
    rd_word  = mem[widx];
    rd_sh    = rd_word >> {lane, 3'b000};
    nbits    = int'(size_b) * 8;
    if (nbits > int'(N)) begin
      nbits = int'(N);
    end
    sign_bit = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (i == nbits - 1) begin
        sign_bit = rd_sh[i];
      end
    end
    sign_bit = sign_bit & ~bus.funct3[2];
    ld_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      ld_data[i] = (i < nbits) ? rd_sh[i] : sign_bit;
    end
  end

  state_e       state_q, state_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic [A-1:0] fault_addr_q, fault_addr_d;
  logic         fault_sticky_q, fault_sticky_d;

  always_comb begin
    state_d        = StIdle;
    rdata_d        = rdata_q;
    fault_addr_d   = fault_addr_q;
    fault_sticky_d = fault_sticky_q;
    if (bus.fault_clr) begin
      fault_addr_d   = '0;
      fault_sticky_d = 1'b0;
    end
    if (trap) begin
      state_d = StRespFault;
      rdata_d = '0;
      // A fault coinciding with a clear wins and re-arms the capture.
      if (!fault_sticky_q || bus.fault_clr) begin
        fault_addr_d   = bus.addr;
        fault_sticky_d = 1'b1;
      end
    end else if (do_load) begin
      state_d = StRespLoad;
      rdata_d = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      rdata_q        <= '0;
      fault_addr_q   <= '0;
      fault_sticky_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rdata_q        <= rdata_d;
      fault_addr_q   <= fault_addr_d;
      fault_sticky_q <= fault_sticky_d;
    end
  end

  assign bus.rvalid       = (state_q == StRespLoad);
  assign bus.fault        = (state_q == StRespFault);
  assign bus.rdata        = rdata_q;
  assign bus.fault_addr   = fault_addr_q;
  assign bus.fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: one N=32/SIZE=16384 instance and one N=64/SIZE=4096 instance,
// each checked every cycle against a byte-array reference model, plus literal expectations.
module tb_data_memory_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_s   [2];
  logic        we_s    [2];
  logic [2:0]  f3_s    [2];
  logic [31:0] addr_s  [2];
  logic [63:0] wdata_s [2];
  logic        clr_s   [2];
  logic [63:0] rdata_w [2];
  logic        rvalid_w[2];
  logic        fault_w [2];
  logic        sticky_w[2];
  logic [31:0] faddr_w [2];

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned sz_of(int g);
    return (g == 0) ? 16384 : 4096;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned NG = (g == 0) ? 32 : 64;
    localparam int unsigned SZ = (g == 0) ? 16384 : 4096;

    data_memory_lsu_if #(.N(NG), .A(32)) bus ();

    data_memory_lsu #(.N(NG), .A(32), .SIZE(SZ)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.req       = req_s[g];
    assign bus.we        = we_s[g];
    assign bus.funct3    = f3_s[g];
    assign bus.addr      = addr_s[g];
    assign bus.wdata     = wdata_s[g][NG-1:0];
    assign bus.fault_clr = clr_s[g];
    assign rdata_w[g]    = 64'(bus.rdata);
    assign rvalid_w[g]   = bus.rvalid;
    assign fault_w[g]    = bus.fault;
    assign sticky_w[g]   = bus.fault_sticky;
    assign faddr_w[g]    = bus.fault_addr;

    // Reference model: memory as individual bytes, loads assembled arithmetically.
    byte unsigned mem [int unsigned];
    logic [63:0]  exp_rdata;
    logic [31:0]  exp_faddr;
    logic         exp_rvalid, exp_fault, exp_sticky, exp_known;

    always @(posedge clk or posedge rst) begin : model
      int unsigned size;
      bit          illegal, trap, known, sticky;
      logic [63:0] v;
      logic [31:0] faddr, a;
      logic [2:0]  f3;
      if (rst) begin
        exp_rdata  <= '0;
        exp_rvalid <= 1'b0;
        exp_fault  <= 1'b0;
        exp_sticky <= 1'b0;
        exp_faddr  <= '0;
        exp_known  <= 1'b1;
      end else begin
        f3      = f3_s[g];
        a       = addr_s[g];
        size    = 1 << f3[1:0];
        illegal = (f3 == 3'd7) || (NG == 32 && (f3 == 3'd3 || f3 == 3'd6))
               || (we_s[g] && f3[2]);
        trap    = illegal || (a % size != 0) || (a >= SZ);
        sticky  = exp_sticky;
        faddr   = exp_faddr;
        if (clr_s[g]) begin
          sticky = 1'b0;
          faddr  = '0;
        end
        exp_rvalid <= 1'b0;
        exp_fault  <= 1'b0;
        if (req_s[g]) begin
          if (trap) begin
            exp_fault <= 1'b1;
            exp_rdata <= '0;
            exp_known <= 1'b1;
            if (!sticky) begin
              sticky = 1'b1;
              faddr  = a;
            end
          end else if (we_s[g]) begin
            for (int i = 0; i < int'(size); i++) mem[a + i] = wdata_s[g][8*i +: 8];
          end else begin
            v     = '0;
            known = 1'b1;
            for (int i = 0; i < int'(size); i++) begin
              if (!mem.exists(a + i)) known = 1'b0;
              else v = v | (64'(mem[a + i]) << (8 * i));
            end
            if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
            if (NG == 32) v[63:32] = '0;
            exp_rvalid <= 1'b1;
            exp_rdata  <= v;
            exp_known  <= known;
          end
        end
        exp_sticky <= sticky;
        exp_faddr  <= faddr;
      end
    end

    always @(negedge clk) begin
      if (!done) begin
        chk($sformatf("n%0d rvalid", NG), 64'(bus.rvalid), 64'(exp_rvalid));
        chk($sformatf("n%0d fault", NG), 64'(bus.fault), 64'(exp_fault));
        chk($sformatf("n%0d sticky", NG), 64'(bus.fault_sticky), 64'(exp_sticky));
        chk($sformatf("n%0d fault_addr", NG), 64'(bus.fault_addr), 64'(exp_faddr));
        if (exp_known) chk($sformatf("n%0d rdata", NG), 64'(bus.rdata), exp_rdata);
      end
    end
  end

  // One access, held for one cycle; returns just after the response edge.
  task automatic acc(int g, logic w, logic [2:0] f3, logic [31:0] a, logic [63:0] d);
    req_s[g]   = 1'b1;
    we_s[g]    = w;
    f3_s[g]    = f3;
    addr_s[g]  = a;
    wdata_s[g] = d;
    @(negedge clk);
    req_s[g] = 1'b0;
    clr_s[g] = 1'b0;
  endtask

  task automatic ld(int g, logic [2:0] f3, logic [31:0] a, logic [63:0] exp, string name);
    acc(g, 1'b0, f3, a, 64'd0);
    chk({name, " rvalid"}, 64'(rvalid_w[g]), 64'd1);
    chk(name, rdata_w[g], exp);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_s[g] = 1'b0; we_s[g] = 1'b0; f3_s[g] = 3'd0;
      addr_s[g] = '0; wdata_s[g] = '0; clr_s[g] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset rdata", rdata_w[0], 64'd0);
    chk("reset rvalid", 64'(rvalid_w[0]), 64'd0);
    chk("reset fault", 64'(fault_w[0]), 64'd0);
    chk("reset fault_addr", 64'(faddr_w[0]), 64'd0);
    chk("reset sticky", 64'(sticky_w[1]), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle rvalid", 64'(rvalid_w[0]), 64'd0);
    chk("idle fault", 64'(fault_w[0]), 64'd0);

    // Sub-word loads and extension.
    acc(0, 1'b1, 3'b010, 32'h100, 64'h80FF7F01);
    chk("store no rvalid", 64'(rvalid_w[0]), 64'd0);
    ld(0, 3'b000, 32'h100, 64'h00000001, "lb 100");
    ld(0, 3'b000, 32'h101, 64'h0000007F, "lb 101");
    ld(0, 3'b000, 32'h102, 64'hFFFFFFFF, "lb 102");
    ld(0, 3'b100, 32'h103, 64'h00000080, "lbu 103");
    ld(0, 3'b001, 32'h102, 64'hFFFF80FF, "lh 102");
    ld(0, 3'b101, 32'h102, 64'h000080FF, "lhu 102");
    @(negedge clk);
    chk("rvalid drops", 64'(rvalid_w[0]), 64'd0);
    chk("rdata held", rdata_w[0], 64'h000080FF);

    // Byte-lane merging.
    acc(0, 1'b1, 3'b010, 32'h200, 64'hAAAAAAAA);
    acc(0, 1'b1, 3'b000, 32'h201, 64'h55);
    acc(0, 1'b1, 3'b001, 32'h202, 64'h1234);
    ld(0, 3'b010, 32'h200, 64'h123455AA, "lw 200 merged");

    // Fault capture and clear.
    acc(0, 1'b0, 3'b001, 32'h101, 64'd0);
    chk("lh mis fault", 64'(fault_w[0]), 64'd1);
    chk("lh mis rdata", rdata_w[0], 64'd0);
    chk("lh mis faddr", 64'(faddr_w[0]), 64'h101);
    chk("lh mis sticky", 64'(sticky_w[0]), 64'd1);
    acc(0, 1'b1, 3'b010, 32'h4000, 64'd0);
    chk("sw oor fault", 64'(fault_w[0]), 64'd1);
    chk("sw oor faddr kept", 64'(faddr_w[0]), 64'h101);
    clr_s[0] = 1'b1;
    @(negedge clk);
    clr_s[0] = 1'b0;
    chk("clr sticky", 64'(sticky_w[0]), 64'd0);
    chk("clr faddr", 64'(faddr_w[0]), 64'd0);
    acc(0, 1'b0, 3'b010, 32'h3, 64'd0);
    clr_s[0] = 1'b1;
    acc(0, 1'b0, 3'b001, 32'h5, 64'd0);
    chk("clr+fault faddr", 64'(faddr_w[0]), 64'h5);
    chk("clr+fault sticky", 64'(sticky_w[0]), 64'd1);

    // Illegal encodings do not write.
    acc(0, 1'b1, 3'b010, 32'h300, 64'h11223344);
    acc(0, 1'b1, 3'b110, 32'h300, 64'hDEADBEEF);
    chk("sw f3=110 fault", 64'(fault_w[0]), 64'd1);
    ld(0, 3'b010, 32'h300, 64'h11223344, "lw 300 unchanged");
    acc(0, 1'b0, 3'b111, 32'h300, 64'd0);
    chk("f3=111 fault", 64'(fault_w[0]), 64'd1);
    acc(0, 1'b0, 3'b011, 32'h300, 64'd0);
    chk("ld on n32 fault", 64'(fault_w[0]), 64'd1);
    acc(0, 1'b1, 3'b010, 32'h3FFC, 64'hCAFEF00D);
    ld(0, 3'b010, 32'h3FFC, 64'hCAFEF00D, "lw last word");

    // 64-bit build.
    acc(1, 1'b1, 3'b011, 32'h8, 64'h0123456789ABCDEF);
    ld(1, 3'b010, 32'hC, 64'h0000000001234567, "n64 lw c");
    ld(1, 3'b110, 32'h8, 64'h0000000089ABCDEF, "n64 lwu 8");
    ld(1, 3'b010, 32'h8, 64'hFFFFFFFF89ABCDEF, "n64 lw 8");
    ld(1, 3'b011, 32'h8, 64'h0123456789ABCDEF, "n64 ld 8");

    // Reset while a load response is pending.
    req_s[0] = 1'b1; we_s[0] = 1'b0; f3_s[0] = 3'b010; addr_s[0] = 32'h200;
    @(posedge clk);
    req_s[0] = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async reset rvalid", 64'(rvalid_w[0]), 64'd0);
    chk("async reset rdata", rdata_w[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomised traffic on both instances.
    for (int it = 0; it < 800; it++) begin
      for (int g = 0; g < 2; g++) begin
        int r;
        r = int'($urandom_range(0, 15));
        req_s[g]   = ($urandom_range(0, 4) != 0);
        we_s[g]    = $urandom_range(0, 1) != 0;
        f3_s[g]    = 3'($urandom_range(0, 7));
        wdata_s[g] = {$urandom, $urandom};
        clr_s[g]   = ($urandom_range(0, 15) == 0);
        if (r == 0)      addr_s[g] = sz_of(g) - (32'd1 << $urandom_range(0, 3));
        else if (r == 1) addr_s[g] = sz_of(g) + $urandom_range(0, 15);
        else             addr_s[g] = $urandom_range(0, 127);
      end
      if (it == 400) begin
        req_s[0] = 1'b0;
        req_s[1] = 1'b0;
        rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
    end
    req_s[0] = 1'b0;
    req_s[1] = 1'b0;
    @(negedge clk);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
# data_memory_lsu

Parametrised byte-addressed data memory for the RISC-V core's MEM stage. It replaces the fixed 32-bit, word-only, combinational-read memory with a memory that has a configurable data width and sub-word load/store support (byte, half, word, and double on 64-bit builds). Loads read synchronously and are sign- or zero-extended. Misaligned, out-of-range and illegal accesses are trapped, and the first trapping address is latched for the core's exception logic.

## Interface
Parameters:
- `N`, 32 — data width in bits; legal values are 32 and 64.
- `A`, 32 — address width in bits.
- `SIZE`, 16384 — capacity in bytes; must be a multiple of N/8.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `req` in 1 — access request, valid for this cycle. There is no backpressure; one access is accepted per cycle.
- `we` in 1 — 1 = store, 0 = load. Qualified by `req`.
- `funct3` in 3 — RISC-V access width/sign code:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD (N=64 only)
  - 100 LBU, 101 LHU, 110 LWU (N=64 only)
- `addr` in A — byte address.
- `wdata` in N — store data, taken from the low-order bytes.
- `rdata` out N — extended load data.
- `rvalid` out 1 — one-cycle pulse: load data valid.
- `fault` out 1 — one-cycle pulse: the accepted access trapped.
- `fault_addr` out A — address of the first trapping access since the last clear.
- `fault_sticky` out 1 — set by any fault; held until cleared.
- `fault_clr` in 1 — synchronous clear of `fault_sticky` and `fault_addr`.

## Operation
Storage and addressing:
- Storage is SIZE/(N/8) words of N bits, each with per-byte write enables.
- Word index is `addr >> log2(N/8)`; byte lane is `addr[log2(N/8)-1:0]`.
- Access size in bytes: B = 1, H = 2, W = 4, D = 8.

An access traps, and is not performed, when any of these holds:
- the address is misaligned for its size (`addr mod size != 0`);
- `addr >= SIZE`;
- `funct3` is illegal: 111 always; 011 or 110 when N=32; any store with `funct3[2]`=1.

A legal store:
- Writes bytes `wdata[8*size-1:0]` into lanes `lane .. lane+size-1` of the addressed word.
- Leaves all other bytes untouched.
- Produces no `rvalid`.

A legal load:
- Reads the word and extracts `size` bytes starting at `lane`.
- Sign-extends to N when `funct3[2]`=0, zero-extends when `funct3[2]`=1.

Fault handling:
- `fault` pulses, `rdata` is 0, and no write occurs.
- If `fault_sticky` is 0, `fault_addr` <= `addr`; `fault_sticky` <= 1.
- When `fault_clr` and a new fault coincide, the new fault wins: sticky stays 1 and `fault_addr` takes the new address.

Other rules:
- `req`=0 performs no access and produces no pulses.
- Response state machine:
  - IDLE -> RESP_LOAD on a legal load;
  - IDLE -> RESP_FAULT on a trapped access;
  - RESP_* -> RESP_* or IDLE per the next cycle's request.
  - Encoded directly as the `rvalid`/`fault` registers.
- Memory contents are not initialised by `rst`; contents are undefined until written.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `fault`=0, `fault_addr`=0, `fault_sticky`=0.
- Load latency is 1 cycle: a request at edge k gives `rdata`/`rvalid` valid after edge k+1, held for exactly one cycle unless another load follows.
- Fault latency is 1 cycle: `fault` and `fault_addr` are updated at edge k+1.
- Store commit happens at the edge the store is sampled.
  - A load to the same word in the next cycle returns the new data.
  - There is no same-cycle read-during-write case (one access per cycle).
- Back-to-back loads give `rvalid` high on consecutive cycles with per-cycle data.
- `rdata` keeps its last value when `rvalid`=0. It is forced to 0 only on a fault response.
- Reset mid-operation: an in-flight response is dropped, and outputs go to reset values immediately. A store sampled on the same edge that `rst` asserts is not guaranteed to commit.

## Test plan
All scenarios use N=32, SIZE=16384 unless stated.
1. Reset -> all outputs 0. Release reset, idle 3 cycles -> `rvalid`=`fault`=0.
2. SW 0x80FF7F01 @0x100; LB @0x100 -> 0x00000001. LB @0x101 -> 0x0000007F. LB @0x102 -> 0xFFFFFFFF. LBU @0x103 -> 0x00000080. LH @0x102 -> 0xFFFF80FF. LHU @0x102 -> 0x000080FF.
3. SW 0xAAAAAAAA @0x200; SB 0x55 @0x201; SH 0x1234 @0x202; LW @0x200 -> 0x123455AA. Each load's `rvalid` is exactly 1 cycle after its request.
4. LH @0x101 -> `fault`=1, `rdata`=0, `fault_addr`=0x101, sticky=1. Then SW @0x4000 -> `fault`=1 while `fault_addr` stays 0x101. Then `fault_clr` -> sticky=0, `fault_addr`=0.
5. SW 0xDEADBEEF @0x300 with `funct3`=110 -> fault, and a later LW @0x300 returns the prior contents. `funct3`=111 load -> fault.
6. N=64, SIZE=4096: SD 0x0123456789ABCDEF @0x8; LW @0xC -> 0x0000000001234567. LWU @0x8 -> 0x0000000089ABCDEF. LW @0x8 -> 0xFFFFFFFF89ABCDEF. Back-to-back loads give 3 consecutive `rvalid` cycles.
